pipeline_sequencer: RTL

- Central stall/flush sequencer for the 5-stage pipelined MIPS core (F, D, E, M, W).
- Merges these stall sources into one per-stage enable and flush vector that drives the pipeline registers:
  - load-use and branch requests from the hazard unit
  - instruction-memory not-ready
  - data-memory wait
  - a fixed-latency multi-cycle multiply/divide unit
- Owns the mult/div busy sequencing.
- Tracks memory-wait timeout and a stall performance counter.

---
 rtl/pipeline_sequencer.sv | 95 +++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: merges dmem wait, mult/div busy, hazard, imem and branch requests
// into per-stage enables/flushes; owns mult/div sequencing, mem timeout and stall count.
module pipeline_sequencer #(
  parameter int MD_LATENCY  = 32,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             HazStallD,
  input  logic             PCSrcD,
  input  logic             imem_ready,
  input  logic             dmem_reqM,
  input  logic             dmem_readyM,
  input  logic             MdStartE,
  output logic             EnF,
  output logic             EnD,
  output logic             EnE,
  output logic             EnM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             md_start,
  output logic             md_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, DWAIT, MDBUSY} state_e;
  localparam logic [7:0]  MD_INIT = 8'(MD_LATENCY - 1);
  localparam logic [16:0] TO      = 17'(MEM_TIMEOUT);
  state_e state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic md_busy_q, md_busy_d, md_pend_q, md_pend_d, md_done_q, md_done_d, mem_err_q, mem_err_d;
  logic dwait, frz, md_run, md_fin, md_hold, launch;
  assign dwait   = dmem_reqM & ~dmem_readyM;
  assign frz     = dwait | mem_err_q;
  assign md_run  = md_busy_q & (md_cnt_q != 8'd0);
  assign md_fin  = md_busy_q & (md_cnt_q == 8'd0);
  // md_done_q marks the mult/div in E as finished so it is not relaunched
  assign md_hold = md_busy_q | md_pend_q | (state_q == DWAIT & MdStartE & ~md_done_q);
  assign launch  = state_q == RUN & MdStartE & ~md_done_q & ~frz & ~HazStallD;
  assign md_busy   = md_busy_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= RUN;
      md_cnt_q    <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      md_busy_q   <= 1'b0;
      md_pend_q   <= 1'b0;
      md_done_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      md_busy_q   <= md_busy_d;
      md_pend_q   <= md_pend_d;
      md_done_q   <= md_done_d;
      mem_err_q   <= mem_err_d;
    end
  always_comb begin
    state_d     = mem_err_q ? state_q : dwait ? DWAIT : launch ? MDBUSY : md_run ? MDBUSY : RUN;
    md_cnt_d    = launch ? MD_INIT : md_run ? md_cnt_q - 8'd1 : md_cnt_q;
    md_busy_d   = launch | md_run;
    md_pend_d   = dwait & (md_fin | md_pend_q);
    md_done_d   = dwait ? md_done_q : md_fin | md_pend_q;
    wait_cnt_d  = !dwait ? '0 : ({1'b0, wait_cnt_q} < TO) ? wait_cnt_q + 16'd1 : wait_cnt_q;
    mem_err_d   = mem_err_q | (dwait & ({1'b0, wait_cnt_q} + 17'd1 >= TO));
    stall_cnt_d = (~EnF & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_comb begin
    {EnF, EnD, EnE, EnM} = 4'hF;
    {FlushD, FlushE, FlushM, FlushW} = 4'h0;
    md_start = 1'b0;
    if (frz) begin
      {EnF, EnD, EnE, EnM} = 4'h0;
      FlushW = 1'b1;
    end else if (md_hold | launch) begin
      {EnF, EnD, EnE} = 3'b000;
      FlushM = 1'b1;
      md_start = launch;
    end else if (HazStallD | ~imem_ready) begin
      {EnF, EnD} = 2'b00;
      FlushE = 1'b1;
    end else
      FlushD = PCSrcD;
  end
endmodule
